// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared state encodings and constants for the pipeline controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_FLUSH = 2'd1,
        CTRL_STALL = 2'd2
    } ctrl_state_e;

    localparam int          C_FLUSH_CYCLES_DEFAULT = 2;
    localparam int          C_FLUSH_CNT_W          = 3;
    localparam logic [15:0] C_INST_NOP             = 16'h6000;

    // Counter preload so that the flush lasts exactly `cycles` cycles.
    function automatic logic [C_FLUSH_CNT_W-1:0] flush_load(input int cycles);
        return C_FLUSH_CNT_W'(cycles - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module  : pipe_ctrl_if
// Brief   : EX-stage request/handshake bundle and pipeline control outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  jump_req_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  mc_start_i;
    logic                  mc_done_i;

    logic                  jump_flag_o;
    logic                  pc_we_o;
    logic [ADDR_WIDTH-1:0] jump_addr_o;
    logic                  hold_o;
    logic [1:0]            state_o;
    logic                  timeout_o;

    modport master (
        output jump_req_i, jump_addr_i, mc_start_i, mc_done_i,
        input  jump_flag_o, pc_we_o, jump_addr_o, hold_o, state_o, timeout_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, mc_start_i, mc_done_i,
        output jump_flag_o, pc_we_o, jump_addr_o, hold_o, state_o, timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl_wdt.sv
// ============================================================================
// Module  : pipe_ctrl_wdt
// Brief   : Stall watchdog: counts STALL cycles, forces exit at STALL_TIMEOUT
//           and raises a sticky flag. Compiled only with PIPE_CTRL_WDT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef PIPE_CTRL_WDT_EN
module pipe_ctrl_wdt #(
    parameter int STALL_TIMEOUT = 255
)(
    input  logic clk,
    input  logic rst_n,
    input  logic in_stall_i,
    output logic expire_o,
    output logic timeout_o
);
    localparam logic [15:0] C_LIMIT = 16'(STALL_TIMEOUT - 1);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    // Counter sits at zero outside STALL, so every entry starts from a clean count.
    always_comb begin
        stall_cnt_d = in_stall_i ? stall_cnt_q + 16'd1 : 16'd0;
        expire_o    = in_stall_i && (stall_cnt_q == C_LIMIT);
        timeout_d   = timeout_q | expire_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
endmodule
`endif

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : J1 pipeline controller: redirect flush windows and multi-cycle
//           stall windows. Optional stall watchdog under PIPE_CTRL_WDT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 13,
    parameter int FLUSH_CYCLES  = C_FLUSH_CYCLES_DEFAULT,
    parameter int STALL_TIMEOUT = 255
)(
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    ctrl_state_e              state_q, state_d;
    logic [C_FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                     jump_flag_q, jump_flag_d;
    logic                     pc_we_q, pc_we_d;
    logic                     hold_q, hold_d;
    logic [ADDR_WIDTH-1:0]    jump_addr_q, jump_addr_d;

    logic                     w_wdt_expire;
    logic                     w_wdt_timeout;

`ifdef PIPE_CTRL_WDT_EN
    pipe_ctrl_wdt #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_wdt (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_stall_i (state_q == CTRL_STALL),
        .expire_o   (w_wdt_expire),
        .timeout_o  (w_wdt_timeout)
    );
`else
    assign w_wdt_expire  = 1'b0;
    assign w_wdt_timeout = 1'b0;
`endif

    // Outputs are next-state decoded so each one is a plain flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        jump_flag_d = 1'b0;
        pc_we_d     = 1'b0;
        hold_d      = 1'b0;
        jump_addr_d = jump_addr_q;

        case (state_q)
            CTRL_RUN: begin
                if (bus.jump_req_i) begin
                    state_d     = CTRL_FLUSH;
                    cnt_d       = flush_load(FLUSH_CYCLES);
                    jump_flag_d = 1'b1;
                    pc_we_d     = 1'b1;
                    jump_addr_d = bus.jump_addr_i;
                end else if (bus.mc_start_i && !bus.mc_done_i) begin
                    state_d = CTRL_STALL;
                    hold_d  = 1'b1;
                end
            end
            CTRL_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = CTRL_RUN;
                end else begin
                    cnt_d       = cnt_q - {{(C_FLUSH_CNT_W-1){1'b0}}, 1'b1};
                    jump_flag_d = 1'b1;
                end
            end
            CTRL_STALL: begin
                if (bus.mc_done_i || w_wdt_expire) begin
                    state_d = CTRL_RUN;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: begin
                state_d = CTRL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CTRL_RUN;
            cnt_q       <= '0;
            jump_flag_q <= 1'b0;
            pc_we_q     <= 1'b0;
            hold_q      <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            jump_flag_q <= jump_flag_d;
            pc_we_q     <= pc_we_d;
            hold_q      <= hold_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    assign bus.jump_flag_o = jump_flag_q;
    assign bus.pc_we_o     = pc_we_q;
    assign bus.jump_addr_o = jump_addr_q;
    assign bus.hold_o      = hold_q;
    assign bus.state_o     = state_q;
    assign bus.timeout_o   = w_wdt_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Brief   : Directed self-checking bench for pipe_ctrl (PIPE_CTRL_WDT_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;
    localparam int AW = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_WIDTH(AW)) bus  ();
    pipe_ctrl_if #(.ADDR_WIDTH(AW)) bus1 ();

    pipe_ctrl #(
        .ADDR_WIDTH    (AW),
        .FLUSH_CYCLES  (2),
        .STALL_TIMEOUT (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pipe_ctrl #(
        .ADDR_WIDTH    (AW),
        .FLUSH_CYCLES  (1),
        .STALL_TIMEOUT (8)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic flag, input logic pcwe,
                              input logic hold, input logic [1:0] st, input logic [AW-1:0] addr);
        check({tag, ".jump_flag"}, 32'(bus.jump_flag_o), 32'(flag));
        check({tag, ".pc_we"},     32'(bus.pc_we_o),     32'(pcwe));
        check({tag, ".hold"},      32'(bus.hold_o),      32'(hold));
        check({tag, ".state"},     32'(bus.state_o),     32'(st));
        check({tag, ".jump_addr"}, 32'(bus.jump_addr_o), 32'(addr));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.jump_req_i   = 1'b0;
        bus.jump_addr_i  = '0;
        bus.mc_start_i   = 1'b0;
        bus.mc_done_i    = 1'b0;
        bus1.jump_req_i  = 1'b0;
        bus1.jump_addr_i = '0;
        bus1.mc_start_i  = 1'b0;
        bus1.mc_done_i   = 1'b0;

        repeat (2) tick;
        check_outs("reset", 0, 0, 0, 2'd0, 13'h0000);
        check("reset.timeout", 32'(bus.timeout_o), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick;
            check_outs("idle", 0, 0, 0, 2'd0, 13'h0000);
        end

        // Redirect, with a second (wrong-path) request during the flush
        bus.jump_req_i  = 1'b1;
        bus.jump_addr_i = 13'h0ABC;
        tick;
        check_outs("jmp_c1", 1, 1, 0, 2'd1, 13'h0ABC);
        bus.jump_addr_i = 13'h1111;
        tick;
        check_outs("jmp_c2", 1, 0, 0, 2'd1, 13'h0ABC);
        bus.jump_req_i = 1'b0;
        tick;
        check_outs("jmp_end", 0, 0, 0, 2'd0, 13'h0ABC);

        // Single-cycle flush instance
        bus1.jump_req_i  = 1'b1;
        bus1.jump_addr_i = 13'h1FFF;
        tick;
        bus1.jump_req_i = 1'b0;
        check("f1_c1.flag",  32'(bus1.jump_flag_o), 32'd1);
        check("f1_c1.pc_we", 32'(bus1.pc_we_o),     32'd1);
        check("f1_c1.state", 32'(bus1.state_o),     32'd1);
        check("f1_c1.addr",  32'(bus1.jump_addr_o), 32'h1FFF);
        tick;
        check("f1_end.flag",  32'(bus1.jump_flag_o), 32'd0);
        check("f1_end.pc_we", 32'(bus1.pc_we_o),     32'd0);
        check("f1_end.state", 32'(bus1.state_o),     32'd0);

        // Stall window with ignored jump and extra start inside it
        bus.mc_start_i = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        check_outs("stall_in", 0, 0, 1, 2'd2, 13'h0ABC);
        bus.jump_req_i  = 1'b1;
        bus.jump_addr_i = 13'h0555;
        tick;
        bus.jump_req_i = 1'b0;
        check_outs("stall_jmp", 0, 0, 1, 2'd2, 13'h0ABC);
        bus.mc_start_i = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        check_outs("stall_start", 0, 0, 1, 2'd2, 13'h0ABC);
        bus.mc_done_i = 1'b1;
        tick;
        bus.mc_done_i = 1'b0;
        check_outs("stall_done", 0, 0, 0, 2'd0, 13'h0ABC);

        bus.mc_done_i = 1'b1;
        tick;
        bus.mc_done_i = 1'b0;
        check_outs("stray_done", 0, 0, 0, 2'd0, 13'h0ABC);

        bus.mc_start_i = 1'b1;
        bus.mc_done_i  = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        bus.mc_done_i  = 1'b0;
        check_outs("mc_1cyc", 0, 0, 0, 2'd0, 13'h0ABC);
        tick;
        check_outs("mc_1cyc2", 0, 0, 0, 2'd0, 13'h0ABC);

        // Jump and start together: jump wins
        bus.jump_req_i  = 1'b1;
        bus.jump_addr_i = 13'h0123;
        bus.mc_start_i  = 1'b1;
        tick;
        bus.jump_req_i = 1'b0;
        bus.mc_start_i = 1'b0;
        check_outs("jmp_win1", 1, 1, 0, 2'd1, 13'h0123);
        tick;
        check_outs("jmp_win2", 1, 0, 0, 2'd1, 13'h0123);
        tick;
        check_outs("jmp_win3", 0, 0, 0, 2'd0, 13'h0123);

`ifndef PIPE_CTRL_WDT_EN
        bus.mc_start_i = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        repeat (20) tick;
        check_outs("long_stall", 0, 0, 1, 2'd2, 13'h0123);
        check("long_stall.timeout", 32'(bus.timeout_o), 32'd0);
        bus.mc_done_i = 1'b1;
        tick;
        bus.mc_done_i = 1'b0;
        check_outs("long_done", 0, 0, 0, 2'd0, 13'h0123);
`else
        bus.mc_start_i = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("wdt_c%0d.hold", c), 32'(bus.hold_o), 32'd1);
            check($sformatf("wdt_c%0d.timeout", c), 32'(bus.timeout_o), 32'd0);
            tick;
        end
        check_outs("wdt_exp", 0, 0, 0, 2'd0, 13'h0123);
        check("wdt_exp.timeout", 32'(bus.timeout_o), 32'd1);
        bus.mc_done_i = 1'b1;
        tick;
        bus.mc_done_i = 1'b0;
        check_outs("wdt_late", 0, 0, 0, 2'd0, 13'h0123);
        check("wdt_late.timeout", 32'(bus.timeout_o), 32'd1);
        tick;
        check("wdt_sticky", 32'(bus.timeout_o), 32'd1);
`endif

        // Asynchronous reset in the middle of a flush
        bus.jump_req_i  = 1'b1;
        bus.jump_addr_i = 13'h0777;
        tick;
        bus.jump_req_i = 1'b0;
        check_outs("pre_rst_f", 1, 1, 0, 2'd1, 13'h0777);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_flush", 0, 0, 0, 2'd0, 13'h0000);
        check("rst_flush.timeout", 32'(bus.timeout_o), 32'd0);
        rst_n = 1'b1;
        tick;
        check_outs("post_rst_f", 0, 0, 0, 2'd0, 13'h0000);

        // Asynchronous reset in the middle of a stall
        bus.mc_start_i = 1'b1;
        tick;
        bus.mc_start_i = 1'b0;
        tick;
        check_outs("pre_rst_s", 0, 0, 1, 2'd2, 13'h0000);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_stall", 0, 0, 0, 2'd0, 13'h0000);
        rst_n = 1'b1;
        tick;
        check_outs("post_rst_s", 0, 0, 0, 2'd0, 13'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
